data_sram_resp: RTL
===================

# data_sram_resp

Data-side SRAM responder for the five-stage pipeline. It serves the data SRAM request the EX stage issues: `data_sram_en`, byte write enables, address and write data. It returns `data_sram_rdata`, which the MEM stage consumes one pipeline cycle after the request advances. A programmable wait-state counter models slow memory and raises `stallreq` to the stall controller until the access completes.

## Interface
- `ADDR_W`, default 10: word-address width; array depth is 2^ADDR_W 32-bit words.
- `WAIT_CYCLES`, default 0: stall cycles inserted per access; legal range 0..15.
- `clk` in 1: clock; all state changes on the rising edge.
- `rst` in 1: reset, asynchronous, active-low.
- `data_sram_en` in 1: request valid.
- `data_sram_wen` in 4: byte write enables; bit i enables `wdata[8i+7:8i]`; all-zero means read.
- `data_sram_addr` in 32: byte address.
- `data_sram_wdata` in 32: write data.
- `data_sram_rdata` out 32: registered read data.
- `stallreq` out 1: stall request to the stall controller.

## Operation
- Word index is `addr[ADDR_W+1:2]`.
  - `addr[1:0]` and the upper address bits are ignored; out-of-range addresses alias.
- Read: `en=1`, `wen=0`. At the access edge `rdata` loads `mem[index]`.
- Write: `en=1`, `wen≠0`. At the access edge only the enabled bytes of `mem[index]` are updated. `rdata` holds its previous value (no read-during-write).
- `rdata` changes only on read access edges and at reset.
- FSM states:
  - IDLE:
    - `en=0`: stay in IDLE.
    - `en=1` and `WAIT_CYCLES=0`: access at this edge, stay in IDLE.
    - `en=1` and `WAIT_CYCLES>0`: latch addr/wen/wdata into request registers and set `cnt <= WAIT_CYCLES-1`. Go to WAIT if `WAIT_CYCLES>1`, else go to ACCESS.
  - WAIT: `cnt <= cnt-1`; go to ACCESS when `cnt==1`.
  - ACCESS: perform the access using the latched request (live inputs ignored), then go to IDLE. `en` still asserted in this cycle belongs to the same instruction and is not re-accepted.
- `stallreq` is combinational: high when in (IDLE with `en=1` and `WAIT_CYCLES≠0`) or in WAIT; low in ACCESS and otherwise.
  - The stall controller holds EX stable while `stallreq=1`. Inputs are therefore stable, but only the latched copy is used after accept.
- Reset:
  - `state=IDLE`, `cnt=0`, `rdata=0`, `stallreq=0`, request registers 0.
  - Memory array is not reset.
  - Reset during WAIT or ACCESS aborts the access; no array write occurs.

## Timing
- `WAIT_CYCLES=0`: request in cycle T, access at the end of T, `rdata` valid in T+1, `stallreq` never asserted.
- `WAIT_CYCLES=W>0`: request first presented in cycle T.
  - `stallreq` is high in cycles T..T+W-1.
  - ACCESS occupies cycle T+W, where `stallreq=0` and EX advances to MEM at the same edge as the access.
  - `rdata` is valid in T+W+1.
  - A new request can be accepted in T+W+1.
- Back-to-back requests with W=0: one access per cycle, no bubbles.
- Back-to-back requests with W>0: throughput is one access per W+1 cycles.
- `rst` deassertion is synchronised externally; the first request is accepted on the first edge after release.

## Structure
- Shared package holds:
  - the state encoding (IDLE=2'd0, WAIT=2'd1, ACCESS=2'd2);
  - the `WAIT_CYCLES` maximum and the counter width (4);
  - the stall-bus index for the data-memory stall request.
- Sub-module `dsram_bank`: a 2^ADDR_W x 32 array with per-byte write enable and a registered read port. The FSM, counter, request latch and `stallreq` logic stay in the top module.

## Test plan
- W=0: write 0xDEADBEEF to 0x40 with wen=4'hF, then read 0x40. Expected: `rdata=0xDEADBEEF` in the cycle after the read; `stallreq` stays 0 throughout.
- Byte enables: preload 0x11223344 at 0x80, write 0xAABBCCDD with wen=4'b0101, read back. Expected: `0x11BB33DD`.
- W=3: read at cycle T. Expected: `stallreq=1` in T..T+2 and 0 in T+3; `rdata` valid in T+4. Change the live address during T+1..T+3; the result must not change.
- Aliasing with ADDR_W=10: write 0x5 to 0x1000_0004, read 0x0000_0004 and 0x0000_0007. Expected: both reads return 0x5.
- Reset mid-access, W=4: assert `rst` low during WAIT of a write. Expected: `stallreq=0` and `rdata=0` immediately; a subsequent read of that address returns the old contents.
- Write then read with W=2: the read returns the new data. During the write, `rdata` holds its prior value.

Source files
------------

// File: rtl/data_sram_resp_pkg.sv
// Shared definitions for the data-side SRAM responder: FSM encoding,
// wait-state counter sizing, stall-bus slot and the byte-merge helper.
package data_sram_resp_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_WAIT   = 2'd1,
        ST_ACCESS = 2'd2
    } dsram_state_e;

    localparam int WAIT_MAX       = 15;
    localparam int CNT_W          = 4;
    localparam int STALL_IDX_DMEM = 3;

    // Replace only the bytes of old_word selected by be with bytes of new_word.
    function automatic logic [31:0] byte_merge(input logic [31:0] old_word,
                                               input logic [31:0] new_word,
                                               input logic [3:0]  be);
        logic [31:0] merged;
        merged = old_word;
        for (int i = 0; i < 4; i++) begin
            if (be[i]) begin
                merged[8*i +: 8] = new_word[8*i +: 8];
            end else begin
                merged[8*i +: 8] = old_word[8*i +: 8];
            end
        end
        return merged;
    endfunction

endpackage

// File: rtl/data_sram_resp_bank.sv
// 2^ADDR_W x 32 data array with per-byte write enables and a registered
// read port; the array itself is deliberately left unreset.
module dsram_bank
    import data_sram_resp_pkg::*;
#(
    parameter int ADDR_W = 10
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [3:0]        wr_be,
    input  logic              rd_en,
    input  logic [ADDR_W-1:0] idx,
    input  logic [31:0]       wdata,
    output logic [31:0]       rdata
);

    logic [31:0] mem_r [2**ADDR_W];
    logic [31:0] rdata_r;

    // Byte-masked array write.
    always_ff @(posedge clk) begin
        if (|wr_be) begin
            mem_r[idx] <= byte_merge(mem_r[idx], wdata, wr_be);
        end
    end

    // Read data register; only read accesses load it.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rdata_r <= 32'd0;
        end else if (rd_en) begin
            rdata_r <= mem_r[idx];
        end
    end

    assign rdata = rdata_r;

endmodule

// File: rtl/data_sram_resp.sv
// Data SRAM responder: accepts EX-stage requests, inserts WAIT_CYCLES stall
// cycles per access and returns registered read data to MEM.
module data_sram_resp
    import data_sram_resp_pkg::*;
#(
    parameter int ADDR_W      = 10,
    parameter int WAIT_CYCLES = 0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        data_sram_en,
    input  logic [3:0]  data_sram_wen,
    input  logic [31:0] data_sram_addr,
    input  logic [31:0] data_sram_wdata,
    output logic [31:0] data_sram_rdata,
    output logic        stallreq
);

    localparam logic [CNT_W-1:0] CNT_PRESET =
        (WAIT_CYCLES > 0) ? CNT_W'(WAIT_CYCLES - 1) : {CNT_W{1'b0}};
    localparam bit HAS_WAIT   = (WAIT_CYCLES > 0);
    localparam bit MULTI_WAIT = (WAIT_CYCLES > 1);

    dsram_state_e      state_r, state_s;
    logic [CNT_W-1:0]  cnt_r, cnt_s;
    logic [ADDR_W-1:0] req_idx_r;
    logic [3:0]        req_wen_r;
    logic [31:0]       req_wdata_r;
    logic              latch_s, acc_s, use_req_s, stall_s;
    logic [ADDR_W-1:0] idx_s;
    logic [3:0]        wen_s;
    logic [31:0]       wdata_s;
    logic              unused_addr_s;

    assign unused_addr_s = ^{data_sram_addr[31:ADDR_W+2], data_sram_addr[1:0]};

    // Next-state, counter and access/stall decode.
    always_comb begin
        state_s   = state_r;
        cnt_s     = cnt_r;
        latch_s   = 1'b0;
        acc_s     = 1'b0;
        use_req_s = 1'b0;
        stall_s   = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (data_sram_en) begin
                    if (HAS_WAIT) begin
                        latch_s = 1'b1;
                        stall_s = 1'b1;
                        cnt_s   = CNT_PRESET;
                        state_s = MULTI_WAIT ? ST_WAIT : ST_ACCESS;
                    end else begin
                        acc_s   = 1'b1;
                        state_s = ST_IDLE;
                    end
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_WAIT: begin
                stall_s = 1'b1;
                cnt_s   = cnt_r - 4'd1;
                if (cnt_r == 4'd1) begin
                    state_s = ST_ACCESS;
                end else begin
                    state_s = ST_WAIT;
                end
            end
            ST_ACCESS: begin
                acc_s     = 1'b1;
                use_req_s = 1'b1;
                state_s   = ST_IDLE;
            end
            default: begin
                state_s = ST_IDLE;
                cnt_s   = {CNT_W{1'b0}};
            end
        endcase
    end

    // After accept the latched request drives the array, never the live bus.
    always_comb begin
        if (use_req_s) begin
            idx_s   = req_idx_r;
            wen_s   = req_wen_r;
            wdata_s = req_wdata_r;
        end else begin
            idx_s   = data_sram_addr[ADDR_W+1:2];
            wen_s   = data_sram_wen;
            wdata_s = data_sram_wdata;
        end
    end

    // FSM, counter and request latch registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r     <= ST_IDLE;
            cnt_r       <= {CNT_W{1'b0}};
            req_idx_r   <= {ADDR_W{1'b0}};
            req_wen_r   <= 4'd0;
            req_wdata_r <= 32'd0;
        end else begin
            state_r <= state_s;
            cnt_r   <= cnt_s;
            if (latch_s) begin
                req_idx_r   <= data_sram_addr[ADDR_W+1:2];
                req_wen_r   <= data_sram_wen;
                req_wdata_r <= data_sram_wdata;
            end
        end
    end

    dsram_bank #(.ADDR_W(ADDR_W)) u_bank (
        .clk   (clk),
        .rst   (rst),
        .wr_be ((acc_s && rst) ? wen_s : 4'd0),
        .rd_en (acc_s && rst && (wen_s == 4'd0)),
        .idx   (idx_s),
        .wdata (wdata_s),
        .rdata (data_sram_rdata)
    );

    assign stallreq = stall_s && rst;

endmodule
